// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the core (C) and a loader/debug master (L): one access per 3 cycles, ack 2 cycles after grant.
// Tie-break: fixed L-over-C by default; define ARB_ROUND_ROBIN_EN to alternate on ties.
module mem_port_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          ph1,
    input  logic          reset_n,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    output logic          c_ack,
    output logic          l_ack,
    output logic [DW-1:0] c_rdata,
    output logic [DW-1:0] l_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_read,
    output logic          mem_write,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic [7:0]    c_wait_cnt
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        state, state_nxt;
    logic          lat_we;
    logic          owner_l;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic [DW-1:0] c_rdata_q, l_rdata_q;
    logic          grant_l;
    logic          resp_rd;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_l;
    // On a tie, L wins only if C took the previous grant.
    assign grant_l = l_req && (!c_req || !last_l);
`else
    assign grant_l = l_req;
`endif

    always_ff @(posedge ph1 or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (c_req || l_req) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        resp_rd   = (state == RESP) && !lat_we;
        mem_read  = (state == ACCESS) && !lat_we;
        mem_write = (state == ACCESS) && lat_we;
        c_ack     = (state == RESP) && !owner_l;
        l_ack     = (state == RESP) && owner_l;
        busy      = (state != IDLE);
        // Read data is forwarded straight from memory in the ack cycle, then held.
        c_rdata   = (resp_rd && !owner_l) ? mem_rdata : c_rdata_q;
        l_rdata   = (resp_rd && owner_l) ? mem_rdata : l_rdata_q;
    end

    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;

    always_ff @(posedge ph1 or negedge reset_n) begin
        if (!reset_n) begin
            lat_we     <= 1'b0;
            owner_l    <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            c_rdata_q  <= '0;
            l_rdata_q  <= '0;
            c_wait_cnt <= 8'd0;
`ifdef ARB_ROUND_ROBIN_EN
            last_l     <= 1'b0;
`endif
        end else begin
            if (state == IDLE && (c_req || l_req)) begin
                owner_l   <= grant_l;
                lat_we    <= grant_l ? l_we : c_we;
                lat_addr  <= grant_l ? l_addr : c_addr;
                lat_wdata <= grant_l ? l_wdata : c_wdata;
`ifdef ARB_ROUND_ROBIN_EN
                last_l    <= grant_l;
`endif
            end
            if (resp_rd) begin
                if (owner_l) l_rdata_q <= mem_rdata;
                else         c_rdata_q <= mem_rdata;
            end
            if (c_req && !c_ack && c_wait_cnt != 8'hFF) begin
                c_wait_cnt <= c_wait_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random and directed traffic on both ports against a transaction-schedule reference model.
module tb_mem_port_arbiter;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         gap;
    } op_t;

    logic       ph1 = 1'b0;
    logic       reset_n = 1'b0;
    logic       c_req = 1'b0, c_we = 1'b0, l_req = 1'b0, l_we = 1'b0;
    logic [7:0] c_addr = '0, c_wdata = '0, l_addr = '0, l_wdata = '0;
    logic       c_ack, l_ack, mem_read, mem_write, busy;
    logic [7:0] c_rdata, l_rdata, mem_addr, mem_wdata, c_wait_cnt;
    logic [7:0] mem_rdata = '0;

    mem_port_arbiter #(.AW(8), .DW(8)) dut (
        .ph1(ph1), .reset_n(reset_n),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .c_ack(c_ack), .l_ack(l_ack), .c_rdata(c_rdata), .l_rdata(l_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata),
        .busy(busy), .c_wait_cnt(c_wait_cnt)
    );

    always #5 ph1 = ~ph1;

    function automatic logic [7:0] init_val(input int i);
        logic [7:0] v;
        v = 8'(i * 7 + 3);
        if (i == 16) v = 8'hA5;
        return v;
    endfunction

    // Memory seen by the DUT: read data valid the cycle after mem_read.
    logic [7:0] env_mem [256];
    bit         loaded = 1'b0;
    always @(posedge ph1) begin
        if (!loaded) begin
            for (int i = 0; i < 256; i++) env_mem[i] <= init_val(i);
            loaded <= 1'b1;
        end else begin
            if (mem_read)  mem_rdata <= env_mem[mem_addr];
            if (mem_write) env_mem[mem_addr] <= mem_wdata;
        end
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: one outstanding access, strobe one cycle after the grant, ack the cycle after that.
    logic [7:0] ref_mem [256];
    int         t = 0;
    int         s_t = -100;
    logic       s_l, s_we;
    logic [7:0] s_addr, s_wdata;
    int         cnt_m = 0;
    bit         c_done = 0, l_done = 0;
    int         c_gap = -1, l_gap = -1;
    op_t        c_q[$], l_q[$];
    bit         ack_log[$];
`ifdef ARB_ROUND_ROBIN_EN
    bit         last_l = 0;
`endif

    function automatic bit l_has_prio();
`ifdef ARB_ROUND_ROBIN_EN
        return !last_l;
`else
        return 1'b1;
`endif
    endfunction

    task automatic eval_cycle(output bit strobe_now);
        bit         es, ea, win;
        logic [7:0] exp_rd;
        exp_rd = '0;
        es = (t == s_t);
        ea = (t == s_t + 1);
        strobe_now = es;
        chk("mem_read", mem_read, es && !s_we);
        chk("mem_write", mem_write, es && s_we);
        if (es) begin
            chk("mem_addr", mem_addr, s_addr);
            if (s_we) chk("mem_wdata", mem_wdata, s_wdata);
        end
        if (ea) begin
            if (s_we) ref_mem[s_addr] = s_wdata;
            else      exp_rd = ref_mem[s_addr];
        end
        chk("c_ack", c_ack, ea && !s_l);
        chk("l_ack", l_ack, ea && s_l);
        if (ea && !s_we) begin
            if (s_l) chk("l_rdata", l_rdata, exp_rd);
            else     chk("c_rdata", c_rdata, exp_rd);
        end
        chk("busy", busy, es || ea);
        chk("c_wait_cnt", c_wait_cnt, cnt_m);
        if (c_ack) ack_log.push_back(1'b0);
        if (l_ack) ack_log.push_back(1'b1);
        if (c_req && !(ea && !s_l) && cnt_m < 255) cnt_m++;
        if (ea) begin
            if (s_l) l_done = 1;
            else     c_done = 1;
        end
        if (!es && !ea && (c_req || l_req)) begin
            win     = l_req && (!c_req || l_has_prio());
            s_t     = t + 1;
            s_l     = win;
            s_we    = win ? l_we : c_we;
            s_addr  = win ? l_addr : c_addr;
            s_wdata = win ? l_wdata : c_wdata;
`ifdef ARB_ROUND_ROBIN_EN
            last_l  = win;
`endif
        end
    endtask

    task automatic drive_agents();
        if (c_done) begin c_q.delete(0); c_done = 0; c_gap = -1; end
        if (l_done) begin l_q.delete(0); l_done = 0; l_gap = -1; end
        if (c_q.size() > 0) begin
            if (c_gap < 0) c_gap = c_q[0].gap;
            if (c_gap > 0) begin c_req = 0; c_gap--; end
            else begin c_req = 1; c_we = c_q[0].we; c_addr = c_q[0].addr; c_wdata = c_q[0].wdata; end
        end else c_req = 0;
        if (l_q.size() > 0) begin
            if (l_gap < 0) l_gap = l_q[0].gap;
            if (l_gap > 0) begin l_req = 0; l_gap--; end
            else begin l_req = 1; l_we = l_q[0].we; l_addr = l_q[0].addr; l_wdata = l_q[0].wdata; end
        end else l_req = 0;
    endtask

    task automatic step(input bit stop_on_strobe, output bit hit);
        bit sn;
        @(negedge ph1);
        eval_cycle(sn);
        hit = sn;
        if (stop_on_strobe && sn) return;
        @(posedge ph1);
        #1;
        drive_agents();
        t++;
    endtask

    task automatic drain(input int max_cycles);
        int n;
        bit h;
        n = 0;
        while ((c_q.size() > 0 || l_q.size() > 0 || t == s_t || t == s_t + 1) && n < max_cycles) begin
            step(1'b0, h);
            n++;
        end
        if (n >= max_cycles) chk("drain_timeout", 1, 0);
    endtask

    task automatic push_op(input bit to_l, input logic we, input logic [7:0] a, input logic [7:0] d, input int gap);
        op_t o;
        o.we = we; o.addr = a; o.wdata = d; o.gap = gap;
        if (to_l) l_q.push_back(o);
        else      c_q.push_back(o);
    endtask

    task automatic reset_checks(input string pfx);
        chk({pfx, "_mem_read"}, mem_read, 0);
        chk({pfx, "_mem_write"}, mem_write, 0);
        chk({pfx, "_c_ack"}, c_ack, 0);
        chk({pfx, "_l_ack"}, l_ack, 0);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_wait_cnt"}, c_wait_cnt, 0);
        chk({pfx, "_mem_addr"}, mem_addr, 0);
        chk({pfx, "_mem_wdata"}, mem_wdata, 0);
        chk({pfx, "_c_rdata"}, c_rdata, 0);
        chk({pfx, "_l_rdata"}, l_rdata, 0);
    endtask

    task automatic model_reset();
        s_t = -100; cnt_m = 0; c_done = 0; l_done = 0; c_gap = -1; l_gap = -1;
        c_q.delete(); l_q.delete();
`ifdef ARB_ROUND_ROBIN_EN
        last_l = 0;
`endif
    endtask

    initial begin
        bit h;
        bit exp_order [8];
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);

        // Power-on reset
        @(posedge ph1); @(posedge ph1);
        @(negedge ph1);
        reset_checks("rst");
        @(posedge ph1); #2 reset_n = 1'b1;

        // Single core read of preloaded 0x10
        push_op(0, 0, 8'h10, 8'h00, 0);
        drain(50);
        chk("single_rd_cnt", c_wait_cnt, 2);
        chk("single_rd_data", c_rdata, 8'hA5);

        // Loader write, then core reads it back
        push_op(1, 1, 8'h20, 8'h3C, 0);
        push_op(0, 0, 8'h20, 8'h00, 4);
        drain(50);
        chk("wr_rd_data", c_rdata, 8'h3C);

        // Simultaneous requests, four back-to-back reads each
        ack_log.delete();
        for (int i = 0; i < 4; i++) begin
            push_op(0, 0, 8'(8'h50 + i), 8'h00, 0);
            push_op(1, 0, 8'(8'h60 + i), 8'h00, 0);
        end
        drain(100);
`ifdef ARB_ROUND_ROBIN_EN
        for (int i = 0; i < 8; i++) exp_order[i] = (i % 2 == 0);
`else
        for (int i = 0; i < 8; i++) exp_order[i] = (i < 4);
`endif
        chk("tie_ack_count", ack_log.size(), 8);
        for (int i = 0; i < 8 && i < ack_log.size(); i++)
            chk($sformatf("tie_order_%0d", i), ack_log[i], exp_order[i]);

        // Loader arrives while the core access is in flight
        push_op(0, 0, 8'h11, 8'h00, 0);
        push_op(1, 1, 8'h12, 8'h77, 1);
        drain(50);

        // Reset during the strobe of a core write: the write must be abandoned
        push_op(0, 1, 8'h30, 8'hEE, 0);
        h = 0;
        for (int n = 0; n < 20 && !h; n++) step(1'b1, h);
        chk("mid_rst_reached_strobe", h, 1);
        #1 reset_n = 1'b0; c_req = 1'b0; l_req = 1'b0;
        #1 reset_checks("mid_rst");
        model_reset();
        @(posedge ph1); @(posedge ph1); #2 reset_n = 1'b1;
        t += 2;
        push_op(0, 0, 8'h30, 8'h00, 0);
        drain(50);
        chk("mid_rst_abandoned_wr", c_rdata, init_val(8'h30));

        // Random mixed traffic on both ports
        for (int i = 0; i < 30; i++) begin
            push_op(0, 1'($urandom_range(0, 1)), 8'($urandom_range(8'h40, 8'h4F)), 8'($urandom), $urandom_range(0, 3));
            push_op(1, 1'($urandom_range(0, 1)), 8'($urandom_range(8'h40, 8'h4F)), 8'($urandom), $urandom_range(0, 3));
        end
        drain(1000);

        // Loader streams continuously while the core keeps one request pending
        push_op(0, 0, 8'h10, 8'h00, 0);
        for (int i = 0; i < 110; i++) push_op(1, 0, 8'(i), 8'h00, 0);
        for (int i = 0; i < 300; i++) step(1'b0, h);
`ifndef ARB_ROUND_ROBIN_EN
        chk("starve_sat_cnt", c_wait_cnt, 255);
`endif
        drain(1000);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the single-port 8-bit program/data memory of the multicycle MIPS top level. It shares the memory between the core (port C) and a program loader/debug master (port L). It serialises accesses through a three-state access FSM, returns read data with a single-cycle acknowledge, and counts core wait cycles for performance checks.

## Interface
- AW, 8, address width
- DW, 8, data width
- ph1  in  1  clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- c_req, l_req  in  1 each  access request; held high with address/data stable until matching ack
- c_we, l_we  in  1 each  1 = write, 0 = read; qualified by req
- c_addr, l_addr  in  AW each  request address
- c_wdata, l_wdata  in  DW each  write data
- c_ack, l_ack  out  1 each  one-cycle completion pulse
- c_rdata, l_rdata  out  DW each  read data; valid in the ack cycle; holds last value otherwise
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_read, mem_write  out  1 each  memory strobes; one-cycle pulse
- mem_rdata  in  DW  memory read data; valid the cycle after mem_read
- busy  out  1  FSM not in IDLE
- c_wait_cnt  out  8  saturating count of cycles with c_req high and no c_ack

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any req is high, select the winner, latch its we/addr/wdata into internal registers, record owner, go to ACCESS. Otherwise stay.
- ACCESS: drive mem_addr/mem_wdata from the latched registers. Assert mem_read (we=0) or mem_write (we=1) for exactly this cycle. Go to RESP.
- RESP: for a read, capture mem_rdata into the owner's rdata register. Pulse the owner's ack. Go to IDLE.
- Outside ACCESS, mem_read and mem_write are 0 and mem_addr/mem_wdata hold their latched values.
- Arbitration happens only in IDLE. A request arriving during ACCESS/RESP waits.
- A requester dropping req before ack is a protocol violation. The latched access still completes and acks.
- Only the owner's ack asserts. c_ack and l_ack are never high together.
- c_wait_cnt: +1 each cycle where c_req=1 and c_ack=0, saturating at 255. Cleared only by reset.

## Timing
- Reset (async assert, sync release) values: state IDLE; all acks 0; mem_read/mem_write 0; mem_addr, mem_wdata, c_rdata, l_rdata 0; busy 0; c_wait_cnt 0; owner C; last-winner C.
- Uncontended latency: req sampled high at edge N (IDLE) → strobe in cycle N+1 → ack in cycle N+2. Reads and writes take the same time.
- Back-to-back: a requester holding req after ack is re-arbitrated in the IDLE cycle after RESP. Throughput is one access per 3 cycles.
- Simultaneous c_req and l_req in IDLE: resolved per Configuration; the loser is served next.
- Reset mid-access (ACCESS or RESP): the in-flight access is abandoned, no ack is issued, and the strobes drop immediately (async).
- busy = 1 in ACCESS and RESP.

## Configuration
- ARB_ROUND_ROBIN_EN defined: round-robin. On a tie, the winner is the port that did not win the most recent grant. The last-winner register updates on every grant.
- Not defined: fixed priority, L always beats C. The last-winner register is removed. A continuously requesting loader can starve the core, which shows up as c_wait_cnt saturating.

## Test plan
- Single read: preload memory[0x10]=0xA5; C reads 0x10 → mem_read pulse at N+1 with mem_addr=0x10, c_ack at N+2, c_rdata=0xA5, c_wait_cnt=2.
- Single write then read: L writes 0x3C to 0x20 → mem_write pulse at N+1; C then reads 0x20 → c_rdata=0x3C.
- Tie: c_req and l_req rise together, each doing 4 back-to-back reads. With ARB_ROUND_ROBIN_EN, grants alternate (L-first after reset is C-last → L, C, L, C …). Without it, all 4 L accesses complete before any C ack.
- Late arrival: L requests during a C ACCESS → L strobe no earlier than 3 cycles after C's strobe; no overlapping acks.
- Reset mid-operation: assert reset_n=0 during ACCESS → strobes drop in the same cycle, no ack; after release, a new C read completes normally.
- Saturation (macro undefined): L requests continuously and C holds req for 300 cycles → c_wait_cnt stops at 255.
